// File: rtl/instr_decoder_fifo.sv
// Instruction capture/decode front end: strobe edge detect, FIFO, output hold stage.
// Ports: clk_en/reset_n, strobe + dataA/dataB in, valid/ready out, FIFO flags; macro DECODER_OPCODE_FILTER_EN.
module instr_decoder_fifo #(
  parameter int DATA_W      = 32,
  parameter int OPCODE_W    = 4,
  parameter int REG_W       = 14,
  parameter int DEPTH       = 8,
  parameter int NUM_OPCODES = 10
) (
  input  logic                       clk_en,
  input  logic                       reset_n,
  input  logic                       new_instruction,
  input  logic [DATA_W-1:0]          dataA,
  input  logic [DATA_W-1:0]          dataB,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OPCODE_W-1:0]        out_opcode,
  output logic [REG_W-1:0]           out_register,
  output logic [DATA_W-1:0]          out_data,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       bad_opcode
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = OPCODE_W + REG_W;
  localparam int EW = FW + DATA_W;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam logic [OPCODE_W:0] NUM_OP =
    NUM_OPCODES[OPCODE_W:0];

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [EW-1:0] entry;

  logic          state;
  logic          strobe_q;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level;

  logic capture;
  logic op_legal;
  logic op_ok;
  logic adv;
  logic pop;
  logic push;
  logic drop;

  logic unused_hi;
  assign unused_hi = ^dataA[DATA_W-1:FW];

  assign entry    = {dataB, dataA[FW-1:0]};
  assign head     = mem[rptr];
  assign capture  = strobe_q & ~new_instruction;
  assign op_legal = {1'b0, dataA[OPCODE_W-1:0]} < NUM_OP;

`ifdef DECODER_OPCODE_FILTER_EN
  assign op_ok = op_legal;

  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      bad_opcode <= 1'b0;
    end else if (capture && !op_legal) begin
      bad_opcode <= 1'b1;
    end
  end
`else
  logic unused_op_legal;
  assign unused_op_legal = op_legal;
  assign op_ok           = 1'b1;
  assign bad_opcode      = 1'b0;
`endif

  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  assign out_valid  = (state == ST_HOLD);

  // The output stage reloads whenever it is empty or its word is taken;
  // a pop frees a slot, so a capture against a full FIFO then still fits.
  assign adv  = (state == ST_EMPTY) | out_ready;
  assign pop  = adv & ~fifo_empty;
  assign push = capture & op_ok & (~fifo_full | pop);
  assign drop = capture & op_ok & fifo_full & ~pop;

  always_ff @(posedge clk_en) begin
    if (push) begin
      mem[wptr] <= entry;
    end
  end

  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q     <= 1'b1;
      state        <= ST_EMPTY;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      out_opcode   <= '0;
      out_register <= '0;
      out_data     <= '0;
    end else begin
      strobe_q <= new_instruction;
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (adv) begin
        state <= pop ? ST_HOLD : ST_EMPTY;
      end
      if (pop) begin
        out_opcode   <= head[OPCODE_W-1:0];
        out_register <= head[FW-1:OPCODE_W];
        out_data     <= head[EW-1:FW];
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder_fifo.sv
// Self-checking bench for instr_decoder_fifo against a queue-based reference model.
// Directed scenarios followed by a randomized phase; one summary line at the end.
module tb_instr_decoder_fifo;

  localparam int DEPTH = 8;
  localparam int NUMOP = 10;

`ifdef DECODER_OPCODE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk_en = 1'b0;
  logic        reset_n;
  logic        new_instruction;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_opcode;
  logic [13:0] out_register;
  logic [31:0] out_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        bad_opcode;

  instr_decoder_fifo dut (
    .clk_en          (clk_en),
    .reset_n         (reset_n),
    .new_instruction (new_instruction),
    .dataA           (dataA),
    .dataB           (dataB),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_opcode      (out_opcode),
    .out_register    (out_register),
    .out_data        (out_data),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .bad_opcode      (bad_opcode)
  );

  always #5 clk_en = ~clk_en;

  typedef struct {
    logic [3:0]  op;
    logic [13:0] rg;
    logic [31:0] d;
  } ins_t;

  ins_t q[$];
  ins_t m_out;
  logic m_valid;
  logic m_ovf;
  logic m_bad;
  logic m_prev;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_out   = '{op: 4'h0, rg: 14'h0, d: 32'h0};
    m_ovf   = 1'b0;
    m_bad   = 1'b0;
    m_prev  = 1'b1;
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    ins_t t;
    if (!m_valid || out_ready) begin
      if (q.size() > 0) begin
        m_out   = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (!new_instruction && m_prev) begin
      t = '{op: dataA[3:0], rg: dataA[17:4], d: dataB};
      if (FILT && int'(t.op) >= NUMOP) m_bad = 1'b1;
      else if (q.size() >= DEPTH) m_ovf = 1'b1;
      else q.push_back(t);
    end
    m_prev = new_instruction;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".op"}, 64'(out_opcode), 64'(m_out.op));
    chk({tag, ".reg"}, 64'(out_register), 64'(m_out.rg));
    chk({tag, ".data"}, 64'(out_data), 64'(m_out.d));
    chk({tag, ".level"}, 64'(fifo_level), 64'(q.size()));
    chk({tag, ".full"}, 64'(fifo_full), 64'(q.size() == DEPTH));
    chk({tag, ".empty"}, 64'(fifo_empty), 64'(q.size() == 0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".bad"}, 64'(bad_opcode), 64'(m_bad));
  endtask

  // Called at a negedge: drive, clock one edge, check at the next negedge.
  task automatic step(string tag, logic ni, logic [31:0] a,
                      logic [31:0] b, logic rdy);
    new_instruction = ni;
    dataA           = a;
    dataB           = b;
    out_ready       = rdy;
    model_edge();
    @(posedge clk_en);
    @(negedge clk_en);
    check_all(tag);
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < DEPTH + 3; i++) step(tag, 1'b1, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic do_reset(string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b1;
    new_instruction = 1'b1;
    dataA           = '0;
    dataB           = '0;
    out_ready       = 1'b0;
    @(negedge clk_en);
    do_reset("reset");

    // Basic capture
    step("cap1", 1'b0, 32'h0003FFF1, 32'h38, 1'b1);
    step("cap2", 1'b1, 32'h0, 32'h0, 1'b1);
    chk("cap.valid", 64'(out_valid), 64'd1);
    chk("cap.op", 64'(out_opcode), 64'h1);
    chk("cap.reg", 64'(out_register), 64'h3FFF);
    chk("cap.data", 64'(out_data), 64'h38);
    drain("cap.drain");

    // Strobe held low for five edges
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 32'h00000125 + i, 32'hA0 + i, 1'b1);
      chk("hold.lvl<=1", 64'(fifo_level <= 1), 64'd1);
    end
    drain("hold.drain");

    // Overflow: ten captures with no downstream acceptance
    for (int i = 0; i < 10; i++) begin
      step("ovf.lo", 1'b0, {14'h0, 14'h100 + 14'(i), 4'(i % NUMOP)},
           32'h1000 + i, 1'b0);
      step("ovf.hi", 1'b1, 32'h0, 32'h0, 1'b0);
    end
    chk("ovf.valid", 64'(out_valid), 64'd1);
    chk("ovf.level", 64'(fifo_level), 64'd8);
    chk("ovf.full", 64'(fifo_full), 64'd1);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.head", 64'(out_data), 64'h1000);
    // Capture while full is accepted because the output pops the same edge
    step("ovf.pp", 1'b0, 32'h00000AB2, 32'h5555, 1'b1);
    chk("ovf.pp.lvl", 64'(fifo_level), 64'd8);
    drain("ovf.drain");
    chk("ovf.empty", 64'(fifo_empty), 64'd1);

    // Backpressure
    step("bp.cap", 1'b0, 32'h00000033, 32'h26425800, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("bp.stall", 1'b1, 32'h0, 32'h0, 1'b0);
      chk("bp.data", 64'(out_data), 64'h26425800);
    end
    step("bp.release", 1'b1, 32'h0, 32'h0, 1'b1);
    chk("bp.drop", 64'(out_valid), 64'd0);

    // Out-of-range opcode
    step("filt.cap", 1'b0, 32'h0000012F, 32'h77, 1'b1);
    step("filt.next", 1'b1, 32'h0, 32'h0, 1'b1);
    chk("filt.valid", 64'(out_valid), 64'(!FILT));
    chk("filt.bad", 64'(bad_opcode), 64'(FILT));
    drain("filt.drain");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 2) != 0), $urandom, $urandom,
           1'($urandom_range(0, 3) != 0));
    end
    drain("rnd.drain");

    // Reset mid-stream with three queued entries
    for (int i = 0; i < 4; i++) begin
      step("rst.lo", 1'b0, 32'h00000045 + 32'(i << 4), 32'hC0 + i, 1'b0);
      step("rst.hi", 1'b1, 32'h0, 32'h0, 1'b0);
    end
    chk("rst.pre", 64'(fifo_level), 64'd3);
    do_reset("rst.async");
    for (int i = 0; i < 4; i++) begin
      step("rst.after", 1'b1, 32'h0, 32'h0, 1'b1);
      chk("rst.novalid", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_decoder_fifo.md
INSTR_DECODER_FIFO -- requirements
Module: instr_decoder_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of dataA, dataB and out_data.
REQ-002 The block SHALL have parameter OPCODE_W, default 4, meaning the opcode field width, taken from dataA[OPCODE_W-1:0].
REQ-003 The block SHALL have parameter REG_W, default 14, meaning the register field width, taken from dataA[OPCODE_W+REG_W-1:OPCODE_W].
REQ-004 The block SHALL have parameter DEPTH, default 8, meaning the number of instruction FIFO entries (power of two, at least 2).
REQ-005 The block SHALL have parameter NUM_OPCODES, default 10, meaning the count of legal opcodes, numbered 0 to NUM_OPCODES-1.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, as the following two port lines state.
REQ-007 clk_en  input  1  single clock; all state updates occur on its rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 new_instruction  input  1  active-low instruction strobe.
REQ-010 dataA  input  DATA_W  carries the opcode and register fields.
REQ-011 dataB  input  DATA_W  carries the data payload.
REQ-012 out_ready  input  1  downstream accepts the presented instruction.
REQ-013 out_valid  output  1  out_opcode, out_register and out_data hold a valid instruction.
REQ-014 out_opcode  output  OPCODE_W  decoded opcode.
REQ-015 out_register  output  REG_W  decoded register field.
REQ-016 out_data  output  DATA_W  copy of dataB.
REQ-017 fifo_full, fifo_empty  output  1 each  FIFO status flags.
REQ-018 fifo_level  output  $clog2(DEPTH+1)  number of occupied FIFO entries.
REQ-019 overflow, bad_opcode  output  1 each  sticky error flags.

Function
REQ-020 A capture SHALL occur at a rising edge where new_instruction is 0 and was 1 at the previous edge (falling-edge detect; the history register resets to 1). Holding the strobe low SHALL produce exactly one capture.
REQ-021 A capture SHALL push the triple {dataA opcode field, dataA register field, dataB}, sampled at that same edge, into the FIFO.
REQ-022 A capture while fifo_full SHALL be dropped and SHALL set overflow, unless the output stage pops at the same edge; in that case the capture SHALL be accepted.
REQ-023 The output stage SHALL have two states. EMPTY: out_valid=0. HOLD: out_valid=1 and out_* stable.
REQ-024 At each edge where the state is EMPTY, or is HOLD with out_ready=1, the output stage SHALL pop the FIFO head into out_* and enter HOLD if the FIFO is non-empty. Otherwise it SHALL go to EMPTY.
REQ-025 Latency: a capture at edge k into an empty FIFO with an EMPTY output stage SHALL give out_valid=1 after edge k+1.
REQ-026 fifo_level SHALL update at every push and pop. A simultaneous push and pop SHALL leave it unchanged.
REQ-027 The read and write pointers SHALL wrap modulo DEPTH.
REQ-028 fifo_full SHALL equal (fifo_level==DEPTH), and fifo_empty SHALL equal (fifo_level==0).
REQ-029 The overflow and bad_opcode flags SHALL clear only on reset.

Reset
REQ-030 While reset_n=0 the block SHALL immediately force the following: out_valid=0, out_opcode=0, out_register=0, out_data=0, pointers=0, fifo_level=0, fifo_empty=1, fifo_full=0, overflow=0, bad_opcode=0, output state EMPTY, strobe history=1.
REQ-031 A reset asserted mid-operation SHALL discard all FIFO contents and the held instruction. No capture SHALL occur on the first edge after release unless new_instruction is 0 at that edge.

Configuration
REQ-032 With macro DECODER_OPCODE_FILTER_EN defined, a capture whose opcode is >= NUM_OPCODES SHALL not be pushed and SHALL set bad_opcode.
REQ-033 Without DECODER_OPCODE_FILTER_EN, all opcodes SHALL be pushed, and bad_opcode SHALL be tied to 0.

Verification
REQ-034 Basic capture: pulse new_instruction low for one cycle with dataA=32'h0003FFF1, dataB=32'h38, out_ready=1. Required: two edges later, out_valid=1, out_opcode=4'b0001, out_register=14'h3FFF, out_data=32'h38.
REQ-035 Strobe held: hold new_instruction low for 5 cycles. Required: exactly one instruction appears and fifo_level never exceeds 1.
REQ-036 Overflow: hold out_ready=0 and issue 10 captures with DEPTH=8. Required: 1 instruction in HOLD, fifo_level=8, fifo_full=1, overflow=1. Then hold out_ready=1. Required: 9 instructions drain in order, then fifo_empty=1.
REQ-037 Backpressure: present dataB=32'h26425800 with out_ready=0 for 4 cycles. Required: out_* stable and out_valid=1. Raise out_ready. Required: out_valid drops after one edge.
REQ-038 Filter: with DECODER_OPCODE_FILTER_EN defined, capture opcode 4'hF. Required: nothing pushed, bad_opcode=1. Without the macro: the instruction is delivered and bad_opcode=0.
REQ-039 Reset mid-stream: with fifo_level=3, pulse reset_n low. Required: all outputs reach their REQ-030 values asynchronously, and no stale instruction appears after release.
